// File: rtl/tick_to_level_pkg.sv
// Shared types and width helpers for the tick_to_level pulse regenerator.
package tick_to_level_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Width of the queued-tick count: holds 0 .. depth inclusive.
  function automatic int pw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Down-counter width: must hold max(hi, lo) - 1, and never be narrower than 1 bit.
  function automatic int cnt_w_of(input int hi, input int lo);
    int m;
    m = (hi > lo) ? hi : lo;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter holding the number of ticks waiting to be replayed.
module pend_counter
  import tick_to_level_pkg::*;
#(
  parameter int DEPTH = 7,
  parameter int W     = pw_of(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign full_o  = (count_q == W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Increment wins if both are requested; the parent never asks for both at once.
  always_comb begin
    count_d = count_q;
    if (inc_i && !full_o) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !empty_o) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tick_to_level.sv
// Regenerates single-cycle ticks as fixed-width level pulses with guaranteed low time.
// Define TICK_TO_LEVEL_QUEUE_EN to queue ticks arriving mid-pulse; otherwise they are dropped.
module tick_to_level
  import tick_to_level_pkg::*;
#(
  parameter  int HIGH_CYCLES = 4,
  parameter  int LOW_CYCLES  = 2,
  parameter  int PEND_DEPTH  = 7,
  localparam int PW          = pw_of(PEND_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          ovf_clr,
  output logic          level,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int            CW        = cnt_w_of(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          busy_q;
  logic          ovf_q;
  logic          ovf_d;

  logic          last_low;
  logic          tick_mid;
  logic          ovf_set;
  logic          retrig;

  // The last LOW cycle is the only busy cycle in which a tick starts a pulse directly.
  assign last_low = (state_q == LOW) && (cnt_q == '0);
  assign tick_mid = tick && (state_q != IDLE) && !last_low;

`ifdef TICK_TO_LEVEL_QUEUE_EN
  logic          pend_inc;
  logic          pend_dec;
  logic          pend_full;
  logic          pend_empty;
  logic [PW-1:0] pend_cnt;

  assign pend_inc = tick_mid && !pend_full;
  assign pend_dec = last_low && !tick && !pend_empty;
  assign ovf_set  = tick_mid && pend_full;
  assign retrig   = last_low && (tick || !pend_empty);
  assign pending  = pend_cnt;

  pend_counter #(
    .DEPTH (PEND_DEPTH),
    .W     (PW)
  ) u_pend (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (pend_inc),
    .dec_i   (pend_dec),
    .count_o (pend_cnt),
    .full_o  (pend_full),
    .empty_o (pend_empty)
  );
`else
  assign ovf_set = tick_mid;
  assign retrig  = last_low && tick;
  assign pending = '0;
`endif

  // A dropped tick in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= HIGH;
            cnt_q   <= HIGH_LOAD;
            level_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            state_q <= LOW;
            cnt_q   <= LOW_LOAD;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        LOW: begin
          if (cnt_q == '0) begin
            if (retrig) begin
              state_q <= HIGH;
              cnt_q   <= HIGH_LOAD;
              level_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign level    = level_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tick_to_level.sv
// Scoreboard bench for tick_to_level with default parameters; expectations follow TICK_TO_LEVEL_QUEUE_EN.
module tb_tick_to_level;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       ovf_clr;
  logic       level;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  always #5 clk = ~clk;

  tick_to_level dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .ovf_clr  (ovf_clr),
    .level    (level),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  typedef struct {
    int   cyc;
    int   scn;
    logic lvl;
    logic bsy;
    int   pend;
    logic ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic t_v[64];
  logic c_v[64];
  logic r_v[64];
  logic e_lvl[64];
  logic e_bsy[64];
  logic e_ovf[64];
  int   e_pend[64];

  task automatic clr_tables();
    for (int i = 0; i < 64; i++) begin
      t_v[i] = 1'b0; c_v[i] = 1'b0; r_v[i] = 1'b0;
      e_lvl[i] = 1'b0; e_bsy[i] = 1'b0; e_ovf[i] = 1'b0; e_pend[i] = 0;
    end
  endtask

  task automatic tick_at(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) t_v[i] = 1'b1;
  endtask
  task automatic lvl_at(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) e_lvl[i] = 1'b1;
  endtask
  task automatic bsy_at(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) e_bsy[i] = 1'b1;
  endtask
  task automatic ovf_at(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) e_ovf[i] = 1'b1;
  endtask
  task automatic pend_at(input int lo, input int hi, input int v);
    for (int i = lo; i <= hi; i++) e_pend[i] = v;
  endtask

  task automatic check1(input string nm, input exp_t e, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s scn%0d cyc%0d: got %0d, want %0d", nm, e.scn, e.cyc, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check1("level",    e, int'(level),    int'(e.lvl));
      check1("busy",     e, int'(busy),     int'(e.bsy));
      check1("pending",  e, int'(pending),  e.pend);
      check1("overflow", e, int'(overflow), int'(e.ovf));
    end
  end

  // Queue-mode pending profile for a tick every cycle from 10 onward.
  task automatic pend_burst(input int last);
    pend_at(12, 12, 1); pend_at(13, 13, 2); pend_at(14, 14, 3); pend_at(15, 15, 4);
    pend_at(16, 17, 5); pend_at(18, 18, 6); pend_at(19, 22, 7);
    pend_at(23, (last < 28) ? last : 28, 6);
    if (last >= 29) pend_at(29, last, 5);
  endtask

  task automatic setup(input int scn);
    clr_tables();
    case (scn)
      1: begin
        tick_at(10, 10); lvl_at(11, 14); bsy_at(11, 16);
      end
      2: begin
        tick_at(10, 10); tick_at(12, 12);
`ifdef TICK_TO_LEVEL_QUEUE_EN
        lvl_at(11, 14); lvl_at(17, 20); bsy_at(11, 22); pend_at(13, 16, 1);
`else
        lvl_at(11, 14); bsy_at(11, 16); ovf_at(13, 31);
`endif
      end
      3: begin
        tick_at(10, 19);
`ifdef TICK_TO_LEVEL_QUEUE_EN
        lvl_at(11, 14); lvl_at(17, 20); lvl_at(23, 26); lvl_at(29, 31);
        bsy_at(11, 31); pend_burst(31); ovf_at(20, 31);
`else
        lvl_at(11, 14); lvl_at(17, 20); bsy_at(11, 22); ovf_at(12, 31);
`endif
      end
      4: begin
        tick_at(10, 20); c_v[20] = 1'b1; c_v[21] = 1'b1;
`ifdef TICK_TO_LEVEL_QUEUE_EN
        lvl_at(11, 14); lvl_at(17, 20); lvl_at(23, 25);
        bsy_at(11, 25); pend_burst(25); ovf_at(20, 21);
`else
        lvl_at(11, 14); lvl_at(17, 20); bsy_at(11, 22); ovf_at(12, 21);
`endif
      end
      5: begin
        tick_at(10, 10); tick_at(12, 13); r_v[13] = 1'b1;
        lvl_at(11, 13); bsy_at(11, 13);
`ifdef TICK_TO_LEVEL_QUEUE_EN
        pend_at(13, 13, 1);
`else
        ovf_at(13, 13);
`endif
      end
      default: begin
        tick_at(10, 10); tick_at(16, 16);
        lvl_at(11, 14); lvl_at(17, 20); bsy_at(11, 22);
      end
    endcase
  endtask

  task automatic run_scn(input int scn, input int ncyc);
    exp_t e;
    setup(scn);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      reset   = r_v[c] | (c == 0);
      tick    = t_v[c];
      ovf_clr = c_v[c];
      if (c >= 2) begin
        e.cyc = c; e.scn = scn; e.lvl = e_lvl[c]; e.bsy = e_bsy[c];
        e.pend = e_pend[c]; e.ovf = e_ovf[c];
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    ovf_clr = 1'b0;
    run_scn(1, 32);
    run_scn(2, 32);
    run_scn(3, 32);
    run_scn(4, 26);
    run_scn(5, 32);
    run_scn(6, 32);
    @(posedge clk);
    #1;
    tick    = 1'b0;
    ovf_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
